dmem_mmio_responder: RTL and testbench

- Memory-side responder for the pipelined core's data-memory port; sits on the dmem_addr/dmem_we/dmem_din/dmem_dout bus.
- Provides a word RAM, a sticky "done" register, a free-running cycle counter, and a byte TX FIFO.
- The FIFO drains through a valid/ready stream, so test programs can emit characters and signal completion to the bench or host.

---
 rtl/dmem_map_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/dmem_mmio_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_map_pkg.sv
// Address map, register offsets and STATUS layout for the data-memory responder.
// Latency: n/a (constants and a pure packing helper).
// Backpressure: n/a.
package dmem_map_pkg;

    localparam logic [31:0] DONE_ADDR_DEFAULT = 32'h0000_2000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_3000;

    localparam logic [31:0] REG_CYCLE_OFS  = 32'h0000_0000;
    localparam logic [31:0] REG_TXDATA_OFS = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS_OFS = 32'h0000_0008;

    localparam logic [31:0] DONE_MAGIC = 32'hDEAD_BEEF;

    localparam int STAT_OVF_BIT   = 11;
    localparam int STAT_FULL_BIT  = 10;
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_CNT_MSB   = 7;
    localparam int STAT_CNT_LSB   = 0;

    // Which target a bus address selects.
    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_DONE,
        REG_CYCLE,
        REG_TXDATA,
        REG_STATUS
    } dmem_region_e;

    // Pack the FIFO state into the STATUS register layout; unused bits read 0.
    function automatic logic [31:0] status_word(input logic       ovf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [7:0] cnt);
        logic [31:0] w;
        w                              = '0;
        w[STAT_OVF_BIT]                = ovf;
        w[STAT_FULL_BIT]               = full;
        w[STAT_EMPTY_BIT]              = empty;
        w[STAT_CNT_MSB:STAT_CNT_LSB]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with first-word fall-through head output.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;
    // Head reads 0 while empty so the stream data is clean after reset.
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, sticky done register, cycle counter, byte TX FIFO.
// Latency: reads combinational from dmem_addr; writes commit at posedge; TX head one cycle after push.
// Backpressure: tx_valid/tx_ready stream; pushes into a full FIFO with no pop are dropped and flag overflow.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] DONE_ADDR  = DONE_ADDR_DEFAULT,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_we,
    input  logic [31:0] dmem_din,
    output logic [31:0] dmem_dout,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done_flag,
    output logic        err_flag
);

    localparam int unsigned RAM_AW = $clog2(DMEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + REG_CYCLE_OFS;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + REG_TXDATA_OFS;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + REG_STATUS_OFS;

    logic [31:0]       ram_q [DMEM_WORDS];
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       cycle_q, cycle_d;

    dmem_region_e      region;
    logic [29:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              addr_lsb_unused;

    logic              tx_push_req;
    logic              tx_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Byte offset within a word is ignored for every target.
    assign word_addr       = dmem_addr[31:2];
    assign addr_lsb_unused = ^dmem_addr[1:0];
    assign ram_idx         = dmem_addr[RAM_AW+1:2];

    // Decode the word address into a target; RAM wins if the map ever overlaps.
    always_comb begin
        region = REG_NONE;
        if (dmem_addr[31:RAM_AW+2] == '0) begin
            region = REG_RAM;
        end else if (word_addr == DONE_ADDR[31:2]) begin
            region = REG_DONE;
        end else if (word_addr == CYCLE_ADDR[31:2]) begin
            region = REG_CYCLE;
        end else if (word_addr == TXDATA_ADDR[31:2]) begin
            region = REG_TXDATA;
        end else if (word_addr == STATUS_ADDR[31:2]) begin
            region = REG_STATUS;
        end
    end

    assign tx_push_req = dmem_we && (region == REG_TXDATA);
    assign tx_pop      = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push_req),
        .push_dat (dmem_din[7:0]),
        .pop      (tx_pop),
        .head_dat (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign tx_valid  = !fifo_empty;
    assign done_flag = done_q;
    assign err_flag  = err_q;

    // Zero-latency read mux; write-only and unmapped targets read as 0.
    always_comb begin
        dmem_dout = '0;
        case (region)
            REG_RAM:    dmem_dout = ram_q[ram_idx];
            REG_DONE:   dmem_dout = {31'b0, done_q};
            REG_CYCLE:  dmem_dout = cycle_q;
            REG_STATUS: dmem_dout = status_word(ovf_q, fifo_full, fifo_empty, 8'(fifo_count));
            default:    dmem_dout = '0;
        endcase
    end

    // Next-state for the sticky flags and the cycle counter.
    always_comb begin
        done_d  = done_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        // Counter stops once done is visible, so the edge that sets done still counts.
        cycle_d = done_q ? cycle_q : cycle_q + 32'd1;
        if (dmem_we && (region == REG_DONE) && (dmem_din == DONE_MAGIC)) begin
            done_d = 1'b1;
        end
        if (region == REG_NONE) begin
            err_d = 1'b1;
        end
        // A push is only lost when full and nothing drains the head this edge.
        if (tx_push_req && fifo_full && !tx_pop) begin
            ovf_d = 1'b1;
        end
    end

    // Sticky flags and cycle counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cycle_q <= '0;
        end else begin
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // Word RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (dmem_we && (region == REG_RAM)) begin
            ram_q[ram_idx] <= dmem_din;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        done_flag;
    logic        err_flag;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] frozen;

    always #5 clk = ~clk;

    dmem_mmio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (dmem_addr),
        .dmem_we   (dmem_we),
        .dmem_din  (dmem_din),
        .dmem_dout (dmem_dout),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .done_flag (done_flag),
        .err_flag  (err_flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Combinational read of one address.
    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        dmem_we   = 1'b0;
        dmem_addr = a;
        #1;
        check_eq(tag, dmem_dout, exp);
    endtask

    // One-cycle word write, then park the bus on a mapped RAM address.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_addr = a;
        dmem_din  = d;
        dmem_we   = 1'b1;
        tick();
        dmem_we   = 1'b0;
        dmem_addr = 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        dmem_addr = 32'h0;
        dmem_we   = 1'b0;
        dmem_din  = 32'h0;
        tx_ready  = 1'b0;
        #1;
        check_eq("rst_done", done_flag, 0);
        check_eq("rst_err", err_flag, 0);
        check_eq("rst_txv", tx_valid, 0);
        check_eq("rst_txd", tx_data, 0);
        #2;
        rst = 1'b0;
        cyc = 0;
        peek(32'h3000, 32'h0, "cycle_at_release");
        tick();
        peek(32'h3000, 32'h1, "cycle_first_edge");
        peek(32'h3008, 32'h0000_0200, "status_reset");

        // RAM round trip, byte-offset alias, read-during-write
        wr(32'h0010, 32'h1234_5678);
        peek(32'h0010, 32'h1234_5678, "ram_rd");
        peek(32'h0013, 32'h1234_5678, "ram_alias");
        wr(32'h0014, 32'h1111_1111);
        dmem_addr = 32'h0014;
        dmem_din  = 32'h9ABC_DEF0;
        dmem_we   = 1'b1;
        #1;
        check_eq("ram_rdw_old", dmem_dout, 32'h1111_1111);
        tick();
        dmem_we = 1'b0;
        #1;
        check_eq("ram_rdw_new", dmem_dout, 32'h9ABC_DEF0);

        // Fill the FIFO with the sink stalled
        for (int i = 0; i < 8; i++) begin
            wr(32'h3004, 32'h0000_0041 + i);
        end
        peek(32'h3008, 32'h0000_0408, "status_full");
        peek(32'h3004, 32'h0, "txdata_reads_zero");
        check_eq("head_first", tx_data, 8'h41);

        // Push while full with a pop on the same edge
        tx_ready = 1'b1;
        wr(32'h3004, 32'h0000_005A);
        tx_ready = 1'b0;
        peek(32'h3008, 32'h0000_0408, "status_push_pop_full");
        check_eq("head_after_pop", tx_data, 8'h42);

        // Push while full, no pop: dropped, overflow sticks
        wr(32'h3004, 32'h0000_0049);
        peek(32'h3008, 32'h0000_0C08, "status_overflow");

        // Drain in order; 0x49 must not appear, 0x5A exits last
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_vld", tx_valid, 1);
            check_eq("drain_dat", tx_data, (i < 7) ? (8'h42 + 8'(i)) : 8'h5A);
            tick();
        end
        tx_ready = 1'b0;
        check_eq("drain_done_vld", tx_valid, 0);
        peek(32'h3008, 32'h0000_0A00, "status_drained");

        // Push into empty FIFO with sink ready: not popped on the push edge
        tx_ready  = 1'b1;
        dmem_addr = 32'h3004;
        dmem_din  = 32'h0000_0061;
        dmem_we   = 1'b1;
        #1;
        check_eq("empty_push_pre_vld", tx_valid, 0);
        tick();
        dmem_we   = 1'b0;
        dmem_addr = 32'h0;
        #1;
        check_eq("empty_push_vld", tx_valid, 1);
        check_eq("empty_push_dat", tx_data, 8'h61);
        tick();
        check_eq("empty_push_popped", tx_valid, 0);
        tx_ready = 1'b0;

        // Done register and counter freeze
        repeat (100) tick();
        peek(32'h3000, 32'(cyc), "cycle_running");
        wr(32'h2000, 32'h0000_0001);
        check_eq("done_wrong_magic", done_flag, 0);
        peek(32'h2000, 32'h0, "done_rd_zero");
        wr(32'h2000, 32'hDEAD_BEEF);
        frozen = 32'(cyc);
        check_eq("done_set", done_flag, 1);
        peek(32'h2000, 32'h1, "done_rd_one");
        peek(32'h2003, 32'h1, "done_rd_alias");
        peek(32'h3000, frozen, "cycle_frozen_0");
        tick();
        peek(32'h3000, frozen, "cycle_frozen_1");
        wr(32'h3000, 32'h0000_0000);
        wr(32'h3008, 32'hFFFF_FFFF);
        peek(32'h3000, frozen, "cycle_write_ignored");
        check_eq("err_still_clear", err_flag, 0);

        // Unmapped access
        peek(32'h5000, 32'h0, "unmapped_rd");
        tick();
        dmem_addr = 32'h0;
        check_eq("err_set", err_flag, 1);
        tx_ready = 1'b1;
        wr(32'h3004, 32'h0000_0077);
        check_eq("stream_vld", tx_valid, 1);
        check_eq("stream_dat", tx_data, 8'h77);
        tick();
        check_eq("stream_popped", tx_valid, 0);
        check_eq("err_sticky", err_flag, 1);
        tx_ready = 1'b0;

        // Reset mid-stream with five bytes queued
        for (int i = 0; i < 5; i++) begin
            wr(32'h3004, 32'h0000_0031 + i);
        end
        peek(32'h3008, 32'h0000_0805, "status_five");
        check_eq("five_vld", tx_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_txv", tx_valid, 0);
        check_eq("midrst_txd", tx_data, 0);
        check_eq("midrst_done", done_flag, 0);
        check_eq("midrst_err", err_flag, 0);
        rst = 1'b0;
        cyc = 0;
        peek(32'h3008, 32'h0000_0200, "status_after_rst");
        peek(32'h3000, 32'h0, "cycle_after_rst");
        peek(32'h0010, 32'h1234_5678, "ram_kept_0");
        tick();
        peek(32'h0014, 32'h9ABC_DEF0, "ram_kept_1");
        peek(32'h3000, 32'(cyc), "cycle_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
